// File: rtl/cpu_pkg.sv
// Shared CPU datapath defaults and byte-merge helper.
// merge_bytes works on MERGE_W bits; callers zero-extend and truncate.
package cpu_pkg;

  localparam int WORD_W   = 16;
  localparam int NREGS    = 8;
  localparam int MERGE_W  = 64;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] merge_bytes(
    input logic [MERGE_W-1:0]  old_w,
    input logic [MERGE_W-1:0]  new_w,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] r;
    for (int i = 0; i < MERGE_BE; i++) begin
      r[8*i +: 8] = be[i] ? new_w[8*i +: 8]
                          : old_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: mux, bypass, zero gating.
// In: raddr, bank, write info, busy_vec. Out: rdata, busy.
module rf_read_port #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [WIDTH-1:0]  regs [DEPTH],
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wmerged,
  input  logic [DEPTH-1:0]  busy_vec,
  output logic [WIDTH-1:0]  rdata,
  output logic              busy
);

  logic zero_hit;
  logic byp_hit;

  // Zero gating excludes the bypass term so the
  // two selects never overlap.
  assign zero_hit = (ZERO_REG != 0) && (raddr == '0);
  assign byp_hit  = (BYPASS != 0) && we &&
                    (raddr == waddr) && !zero_hit;

  always_comb begin
    rdata = regs[raddr];
    unique case (1'b1)
      zero_hit: rdata = '0;
      byp_hit:  rdata = wmerged;
      default:  rdata = regs[raddr];
    endcase
  end

  // Busy reflects registered state only.
  assign busy = busy_vec[raddr];

endmodule

// File: rtl/reg_file_sb.sv
// Byte-enabled register bank, 2 read ports, per-register busy scoreboard.
// Ports: we/waddr/wdata/wbe write, raddr_x/rdata_x read, set_en/set_addr, busy_*.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int DEPTH    = NREGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int NBE     = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [NBE-1:0]    wbe,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [WIDTH-1:0] wmerged;
  logic             wr_ok;

  assign wmerged = WIDTH'(merge_bytes(
                     MERGE_W'(regs_q[waddr]),
                     MERGE_W'(wdata),
                     MERGE_BE'(wbe)));

  assign wr_ok = we &&
                 !((ZERO_REG != 0) && (waddr == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[waddr] = wmerged;
    end
  end

  // Clear first, then set: a new issue to the same
  // register follows the old writeback and wins.
  always_comb begin
    busy_d = busy_q;
    if (we) begin
      busy_d[waddr] = 1'b0;
    end
    if (set_en) begin
      busy_d[set_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  rf_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port_a (
    .raddr    (raddr_a),
    .regs     (regs_q),
    .we       (we),
    .waddr    (waddr),
    .wmerged  (wmerged),
    .busy_vec (busy_q),
    .rdata    (rdata_a),
    .busy     (busy_a)
  );

  rf_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port_b (
    .raddr    (raddr_b),
    .regs     (regs_q),
    .we       (we),
    .waddr    (waddr),
    .wmerged  (wmerged),
    .busy_vec (busy_q),
    .rdata    (rdata_b),
    .busy     (busy_b)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb (bypass and non-bypass instances).
// Stimulus pushes expectations; negedge monitor pops and compares.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic        set_en;
  logic [2:0]  set_addr;

  logic [15:0] rdata_a, rdata_b;
  logic        busy_a, busy_b;
  logic [7:0]  busy_vec;
  logic [15:0] nb_rdata_a, nb_rdata_b;
  logic        nb_busy_a, nb_busy_b;
  logic [7:0]  nb_busy_vec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];

  reg_file_sb dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wbe      (wbe),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .set_en   (set_en),
    .set_addr (set_addr),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .busy_vec (busy_vec)
  );

  reg_file_sb #(.BYPASS(0)) dut_nb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wbe      (wbe),
    .raddr_a  (raddr_a),
    .rdata_a  (nb_rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (nb_rdata_b),
    .set_en   (set_en),
    .set_addr (set_addr),
    .busy_a   (nb_busy_a),
    .busy_b   (nb_busy_b),
    .busy_vec (nb_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_RA  = 0;
  localparam int S_RB  = 1;
  localparam int S_BA  = 2;
  localparam int S_BB  = 3;
  localparam int S_BV  = 4;
  localparam int S_NRA = 5;
  localparam int S_NRB = 6;
  localparam int S_NBA = 7;
  localparam int S_NBB = 8;
  localparam int S_NBV = 9;

  function automatic logic [31:0] actual(int s);
    case (s)
      S_RA:    return 32'(rdata_a);
      S_RB:    return 32'(rdata_b);
      S_BA:    return 32'(busy_a);
      S_BB:    return 32'(busy_b);
      S_BV:    return 32'(busy_vec);
      S_NRA:   return 32'(nb_rdata_a);
      S_NRB:   return 32'(nb_rdata_b);
      S_NBA:   return 32'(nb_busy_a);
      S_NBB:   return 32'(nb_busy_b);
      default: return 32'(nb_busy_vec);
    endcase
  endfunction

  task automatic exp_v(string n, int s, logic [31:0] e);
    exp_t x;
    x.name = n;
    x.sig  = s;
    x.exp  = e;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_all_zero(string n);
    exp_v({n, "_ra"}, S_RA, 0);
    exp_v({n, "_rb"}, S_RB, 0);
    exp_v({n, "_ba"}, S_BA, 0);
    exp_v({n, "_bb"}, S_BB, 0);
    exp_v({n, "_bv"}, S_BV, 0);
    exp_v({n, "_nra"}, S_NRA, 0);
    exp_v({n, "_nrb"}, S_NRB, 0);
    exp_v({n, "_nba"}, S_NBA, 0);
    exp_v({n, "_nbb"}, S_NBB, 0);
    exp_v({n, "_nbv"}, S_NBV, 0);
  endtask

  // Monitor: outputs are combinational, compared
  // mid-cycle on the falling edge.
  initial begin
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = actual(e.sig);
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h",
                   e.name, a, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  logic [7:0] mask;

  initial begin
    rst = 1'b0;
    we = 0; waddr = 0; wdata = 0; wbe = 0;
    raddr_a = 0; raddr_b = 0;
    set_en = 0; set_addr = 0;
    cyc();
    exp_all_zero("reset");
    cyc();
    rst = 1'b1;

    // Full write to r3, bypassed on port A
    we = 1; waddr = 3; wdata = 16'hABCD; wbe = 2'b11;
    raddr_a = 3; raddr_b = 4;
    exp_v("wr3_byp_a", S_RA, 16'hABCD);
    exp_v("wr3_nb_a", S_NRA, 16'h0000);
    exp_v("wr3_other", S_RB, 16'h0000);
    cyc();
    we = 0; raddr_a = 3; raddr_b = 1;
    exp_v("rd3", S_RA, 16'hABCD);
    exp_v("rd3_nb", S_NRA, 16'hABCD);
    exp_v("rd1_zero", S_RB, 16'h0000);
    cyc();

    // Low-byte write
    we = 1; waddr = 3; wdata = 16'h1234; wbe = 2'b01;
    raddr_a = 3; raddr_b = 3;
    exp_v("be01_byp", S_RB, 16'hAB34);
    exp_v("be01_nb_old", S_NRB, 16'hABCD);
    cyc();
    we = 1; waddr = 3; wdata = 16'hFFFF; wbe = 2'b00;
    exp_v("be01_done", S_NRA, 16'hAB34);
    exp_v("be00_byp", S_RA, 16'hAB34);
    cyc();
    we = 0;
    exp_v("be00_hold", S_RA, 16'hAB34);
    exp_v("be00_hold_nb", S_NRB, 16'hAB34);
    cyc();

    // Bypass vs no bypass
    we = 1; waddr = 5; wdata = 16'h00FF; wbe = 2'b11;
    raddr_b = 5;
    exp_v("byp5", S_RB, 16'h00FF);
    exp_v("nobyp5", S_NRB, 16'h0000);
    cyc();
    we = 0;
    exp_v("r5", S_RB, 16'h00FF);
    exp_v("r5_nb", S_NRB, 16'h00FF);
    cyc();

    // Zero register
    we = 1; waddr = 0; wdata = 16'hFFFF; wbe = 2'b11;
    set_en = 1; set_addr = 0;
    raddr_a = 0; raddr_b = 0;
    exp_v("z_byp", S_RA, 16'h0000);
    cyc();
    we = 0; set_en = 0;
    exp_v("z_rd", S_RA, 16'h0000);
    exp_v("z_rd_nb", S_NRB, 16'h0000);
    exp_v("z_busy", S_BV, 8'h00);
    exp_v("z_busy_a", S_BA, 0);
    cyc();

    // Scoreboard: set, set+clear, clear
    set_en = 1; set_addr = 2; raddr_a = 2; raddr_b = 3;
    exp_v("sb_pre", S_BV, 8'h00);
    cyc();
    we = 1; waddr = 2; wdata = 16'h5555; wbe = 2'b11;
    set_en = 1; set_addr = 2;
    exp_v("sb_set", S_BV, 8'h04);
    exp_v("sb_busy_a", S_BA, 1);
    exp_v("sb_busy_b", S_BB, 0);
    exp_v("sb_rd_byp", S_RA, 16'h5555);
    cyc();
    we = 1; waddr = 2; wbe = 2'b00; set_en = 0;
    exp_v("sb_set_wins", S_BV, 8'h04);
    exp_v("sb_be00_rd", S_RA, 16'h5555);
    cyc();
    we = 0;
    exp_v("sb_clear", S_BV, 8'h00);
    exp_v("sb_clear_a", S_BA, 0);
    cyc();

    // Set and clear on different addresses
    set_en = 1; set_addr = 6;
    cyc();
    set_en = 1; set_addr = 1;
    we = 1; waddr = 6; wdata = 16'h6666; wbe = 2'b11;
    exp_v("sb_set6", S_BV, 8'h40);
    cyc();

    // Fill r1..r7 and mark all busy
    mask = 8'h02;
    for (int i = 1; i < 8; i++) begin
      we = 1; waddr = 3'(i);
      wdata = 16'h1000 + 16'(i); wbe = 2'b11;
      set_en = 1; set_addr = 3'(i);
      exp_v($sformatf("fill_bv%0d", i), S_BV, 32'(mask));
      cyc();
      mask = mask | (8'h01 << i);
    end
    we = 0; set_en = 0; raddr_a = 7; raddr_b = 1;
    exp_v("fill_bv", S_BV, 8'hFE);
    exp_v("fill_r7", S_RA, 16'h1007);
    exp_v("fill_r1", S_RB, 16'h1001);
    exp_v("fill_nb_r1", S_NRB, 16'h1001);
    exp_v("fill_ba", S_BA, 1);
    exp_v("fill_bb", S_BB, 1);
    cyc();

    // Mid-cycle async reset, no clock edge before check
    #1;
    rst = 1'b0;
    exp_all_zero("async_rst");
    cyc();
    rst = 1'b1;
    exp_all_zero("rel_rst");
    cyc();
    exp_all_zero("post_rst");
    cyc();

    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      cyc();
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-register storage block for the CPU datapath. It replaces discrete single-word enable registers with a bank of DEPTH words of WIDTH bits. The bank has:
- two combinational read ports;
- one byte-enabled write port;
- optional write-to-read bypass;
- optional hardwired-zero register 0;
- a per-register busy scoreboard, used by the Control Unit for hazard stalls.

Parameters:
WIDTH, 16, data word width in bits; must be a multiple of 8
DEPTH, 8, number of registers; must be a power of two, at least 2
ADDR_W, $clog2(DEPTH), register address width (derived, never overridden)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
we  input  1  write enable from the Control Unit
waddr  input  ADDR_W  write register address
wdata  input  WIDTH  write data
wbe  input  WIDTH/8  write byte enables, bit i selects wdata[8i+7:8i]
raddr_a  input  ADDR_W  read port A address
rdata_a  output  WIDTH  read port A data
raddr_b  input  ADDR_W  read port B address
rdata_b  output  WIDTH  read port B data
set_en  input  1  mark register set_addr busy (instruction issued)
set_addr  input  ADDR_W  register to mark busy
busy_a  output  1  register raddr_a has a pending write
busy_b  output  1  register raddr_b has a pending write
busy_vec  output  DEPTH  full scoreboard, bit n = register n busy

Behaviour:
- Reset: rst low clears every register and every busy bit immediately, without waiting for clk. This applies mid-operation too; any write in that cycle is lost.
- Write:
  - Occurs on the rising clk edge when we=1.
  - Only bytes with wbe[i]=1 take wdata; other bytes hold their value.
  - we=1 with wbe all 0 leaves the data unchanged.
  - we=0 holds all registers.
- Read:
  - rdata_a/rdata_b are combinational from raddr_a/raddr_b, with zero clock latency.
  - Both ports may address the same register.
- Bypass (BYPASS=1): when we=1 and raddr_x==waddr, rdata_x is the byte-merged value (new bytes where wbe=1, stored bytes elsewhere), in the same cycle. With BYPASS=0, rdata_x shows the old value until after the edge.
- Zero register (ZERO_REG=1):
  - Reads of address 0 return 0 regardless of bypass.
  - Writes to 0 are discarded.
  - set_en to 0 is ignored.
  - busy_vec[0] is always 0.
- Scoreboard:
  - Per register: busy bit, updated on the rising edge.
  - set_en=1 sets busy[set_addr].
  - we=1 clears busy[waddr], even when wbe is all 0.
  - Set and clear on the same address in the same cycle: set wins, so busy stays 1 (the new issue follows the old writeback).
  - Set and clear on different addresses: both take effect.
  - set_en on an already-busy register leaves it busy; there is no counting.
- busy_a/busy_b: combinational lookups of busy_vec at raddr_a/raddr_b. They reflect the registered state and are not bypassed by a same-cycle write.
- Out-of-range: not applicable, because DEPTH is a power of two.
- All outputs after reset: rdata_* = 0, busy_* = 0, busy_vec = 0.

Decomposition:
- Shared package cpu_pkg holds:
  - the WORD_W=16 and NREGS=8 defaults;
  - a byte-merge function, merge_bytes(old, new, be), reused by memory-side byte writes.
- One sub-module, rf_read_port: address mux, bypass compare and zero-register gating. It is instantiated twice, for ports A and B.
- Storage and the scoreboard stay in the top module.

Test Plan:
1. Reset, then we=1, waddr=3, wdata=16'hABCD, wbe=2'b11. After the edge, raddr_a=3 gives rdata_a=16'hABCD, and other registers read 0.
2. Register 3 holds 16'hABCD; write wdata=16'h1234 with wbe=2'b01. After the edge, register 3 reads 16'hAB34. A write with wbe=2'b00 leaves 16'hAB34.
3. BYPASS=1: same-cycle we=1, waddr=5, wdata=16'h00FF, raddr_b=5 gives rdata_b=16'h00FF before the edge. With BYPASS=0 in the same stimulus, rdata_b shows the old value 16'h0000 until after the edge.
4. ZERO_REG=1: write register 0 with 16'hFFFF and set_en on address 0. Register 0 reads 16'h0000, and busy_vec[0]=0.
5. Scoreboard sequence:
   - set_en on address 2 gives busy_vec=8'h04.
   - Next cycle, we=1 on waddr=2 together with set_en on address 2: busy_vec stays 8'h04.
   - Next cycle, we only: busy_vec=8'h00.
6. Write registers 1 to 7 and mark all busy. Assert rst low mid-cycle: all rdata and busy_vec go 0 immediately, without a clk edge, and stay 0 after rst is released.
